// File: rtl/vadd_pkg.sv
// -----------------------------------------------------------------------------
// vadd_pkg
// Shared definitions for the vector-add sequencer slice: the default BRAM
// address width, the sequencer FSM state type and a small state decode helper.
// -----------------------------------------------------------------------------
package vadd_pkg;

    // Default address width of the source and destination BRAMs.
    localparam int VADD_DEFAULT_AW = 10;

    // Sequencer phases: waiting, issuing reads, waiting for the write
    // pipeline to empty, and the single completion cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vadd_state_t;

    // The sequencer counts as busy in every phase except IDLE.
    function automatic logic is_busy(input vadd_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/vadd_seq_dly.sv
// -----------------------------------------------------------------------------
// vadd_seq_dly
// RD_LAT-deep shift register carrying a valid flag and an address. Each read
// pushed in at the front emerges at the back exactly RD_LAT cycles later and
// becomes the matching destination write.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   in_valid   a source read is issued this cycle
//   in_addr    address of that read
//   out_valid  write strobe, RD_LAT cycles after the read
//   out_addr   write address, equal to the delayed read address
//   pending    a write is still in flight and will emerge after this cycle
// -----------------------------------------------------------------------------
module vadd_seq_dly #(
    parameter int AW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          pending
);

    logic [RD_LAT-1:0] vld;
    logic [AW-1:0]     addr [RD_LAT];

    // Shift the valid flag and address one stage per clock. Reset empties
    // the pipeline so no stale write can escape after an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                addr[k] <= '0;
            end
        end else begin
            vld[0]  <= in_valid;
            addr[0] <= in_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                vld[k]  <= vld[k-1];
                addr[k] <= addr[k-1];
            end
        end
    end

    // The last stage is the write happening now; only the earlier stages
    // still owe a write in a later cycle.
    always_comb begin
        pending = 1'b0;
        for (int k = 0; k < RD_LAT - 1; k++) begin
            pending = pending | vld[k];
        end
    end

    assign out_valid = vld[RD_LAT-1];
    assign out_addr  = addr[RD_LAT-1];

endmodule

// File: rtl/vadd_sequencer.sv
// -----------------------------------------------------------------------------
// vadd_sequencer
// Walks a vector of len elements: issues one source read per unstalled cycle
// and turns every read into one destination write RD_LAT cycles later, then
// pulses done once all writes have left the pipeline.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   start      request an operation (only looked at in IDLE)
//   len        element count, captured with an accepted start
//   hold       stall: no new source read while high
//   busy       high in RUN, DRAIN and DONE
//   done       one-cycle completion pulse
//   rd_en      source BRAM read enable (both operand BRAMs)
//   rd_addr    source read address
//   wr_en      destination BRAM enable
//   wr_we      destination write enable, identical to wr_en
//   wr_addr    destination write address
//   cycles     (only with VADD_SEQ_CYCCNT_EN) RUN+DRAIN cycle count of the
//              most recent operation, saturating at 16'hFFFF
//
// Build option: define VADD_SEQ_CYCCNT_EN to add the cycles output.
// -----------------------------------------------------------------------------
module vadd_sequencer
    import vadd_pkg::*;
#(
    parameter int AW     = VADD_DEFAULT_AW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] len,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          wr_en,
    output logic          wr_we,
    output logic [AW-1:0] wr_addr
`ifdef VADD_SEQ_CYCCNT_EN
    ,
    output logic [15:0]   cycles
`endif
);

    localparam logic [AW-1:0] ONE = AW'(1);

    vadd_state_t   state;
    logic [AW-1:0] index;
    logic [AW-1:0] len_q;
    logic          last_read;
    logic          pending;

    // Reads go out in the same cycle they are decided, so the read port is
    // a pure decode of the current phase, index and stall input.
    always_comb begin
        rd_en     = (state == RUN) && !hold;
        rd_addr   = rd_en ? index : '0;
        last_read = rd_en && (index == (len_q - ONE));
    end

    // Main sequencer. A zero-length request skips straight to the completion
    // pulse. DONE always returns to IDLE, so a start seen during DONE is
    // dropped and the earliest re-acceptance is the following IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            index <= '0;
            len_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            len_q <= len;
                            index <= '0;
                            state <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        index <= index + ONE;
                        if (last_read) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = is_busy(state);
    assign done = (state == DONE);

    // Every issued read becomes a write RD_LAT cycles later, regardless of
    // any stall that happens in between.
    vadd_seq_dly #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .in_addr   (rd_addr),
        .out_valid (wr_en),
        .out_addr  (wr_addr),
        .pending   (pending)
    );

    assign wr_we = wr_en;

`ifdef VADD_SEQ_CYCCNT_EN
    // Operation length in cycles: restarts on an accepted start, counts
    // RUN and DRAIN cycles, saturates, and is left untouched from DONE on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= 16'd0;
        end else if ((state == IDLE) && start) begin
            cycles <= 16'd0;
        end else if (((state == RUN) || (state == DRAIN)) && (cycles != 16'hFFFF)) begin
            cycles <= cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vadd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vadd_sequencer
// Drives two sequencers (read latency 1 and 2) with identical stimulus and
// compares every output each cycle against a transaction-level reference:
// a read schedule, a table of writes due per cycle and a completion time.
// Define VADD_SEQ_CYCCNT_EN to also cover the cycle counter.
// -----------------------------------------------------------------------------
module tb_vadd_sequencer;

    localparam int AW = 10;

    logic clk;
    logic rst;
    logic start;
    logic hold;
    logic [AW-1:0] len;

    logic [1:0] busyS, doneS, rdEnS, wrEnS, wrWeS;
    logic [AW-1:0] rdAddrS [2];
    logic [AW-1:0] wrAddrS [2];
`ifdef VADD_SEQ_CYCCNT_EN
    logic [15:0] cycS [2];
`endif

    // Reference state per instance.
    int mLat [2];
    bit mBusy [2];
    bit mRun [2];
    int mNext [2];
    int mLen [2];
    int mDoneAt [2];
    bit pendV [2][8];
    int pendA [2][8];
    int mCyc [2];

    int wrSeen [2];
    int lastDone [2];
    int cyc;
    int checks;
    int errors;
    int c0;

    vadd_sequencer #(.AW(AW), .RD_LAT(1)) dutLat1 (
        .clk(clk), .rst(rst), .start(start), .len(len), .hold(hold),
        .busy(busyS[0]), .done(doneS[0]), .rd_en(rdEnS[0]), .rd_addr(rdAddrS[0]),
        .wr_en(wrEnS[0]), .wr_we(wrWeS[0]), .wr_addr(wrAddrS[0])
`ifdef VADD_SEQ_CYCCNT_EN
        , .cycles(cycS[0])
`endif
    );

    vadd_sequencer #(.AW(AW), .RD_LAT(2)) dutLat2 (
        .clk(clk), .rst(rst), .start(start), .len(len), .hold(hold),
        .busy(busyS[1]), .done(doneS[1]), .rd_en(rdEnS[1]), .rd_addr(rdAddrS[1]),
        .wr_en(wrEnS[1]), .wr_we(wrWeS[1]), .wr_addr(wrAddrS[1])
`ifdef VADD_SEQ_CYCCNT_EN
        , .cycles(cycS[1])
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports and counts any mismatch.
    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Compare every output of both instances with the reference for this cycle.
    task automatic checkOutput();
        for (int i = 0; i < 2; i++) begin
            int  slot;
            bit  expRd;
            bit  expWr;
            slot  = cyc % 8;
            expRd = mRun[i] && !hold;
            expWr = pendV[i][slot];
            checkValue($sformatf("lat%0d busy", mLat[i]), 32'(busyS[i]), 32'(mBusy[i]));
            checkValue($sformatf("lat%0d done", mLat[i]), 32'(doneS[i]), 32'(mDoneAt[i] == cyc));
            checkValue($sformatf("lat%0d rd_en", mLat[i]), 32'(rdEnS[i]), 32'(expRd));
            checkValue($sformatf("lat%0d rd_addr", mLat[i]), 32'(rdAddrS[i]), expRd ? 32'(mNext[i]) : 32'd0);
            checkValue($sformatf("lat%0d wr_en", mLat[i]), 32'(wrEnS[i]), 32'(expWr));
            checkValue($sformatf("lat%0d wr_we", mLat[i]), 32'(wrWeS[i]), 32'(expWr));
            if (expWr) begin
                checkValue($sformatf("lat%0d wr_addr", mLat[i]), 32'(wrAddrS[i]), 32'(pendA[i][slot]));
            end
`ifdef VADD_SEQ_CYCCNT_EN
            checkValue($sformatf("lat%0d cycles", mLat[i]), 32'(cycS[i]), 32'(mCyc[i]));
`endif
            if (wrEnS[i] === 1'b1) wrSeen[i]++;
            if (doneS[i] === 1'b1) lastDone[i] = cyc;
        end
    endtask

    // Advance the reference across the coming rising edge.
    task automatic modelAdvance();
        for (int i = 0; i < 2; i++) begin
            int slot;
            bit wasIdle;
            slot    = cyc % 8;
            wasIdle = !mBusy[i];
            pendV[i][slot] = 1'b0;
            if (mBusy[i] && (mDoneAt[i] != cyc) && (mCyc[i] < 65535)) mCyc[i]++;
            if (mRun[i] && !hold) begin
                pendV[i][(cyc + mLat[i]) % 8] = 1'b1;
                pendA[i][(cyc + mLat[i]) % 8] = mNext[i];
                mNext[i]++;
                if (mNext[i] == mLen[i]) begin
                    mRun[i]    = 1'b0;
                    mDoneAt[i] = cyc + mLat[i] + 1;
                end
            end
            if (mDoneAt[i] == cyc) begin
                mBusy[i]   = 1'b0;
                mDoneAt[i] = -1;
            end else if (wasIdle && start) begin
                mBusy[i] = 1'b1;
                mCyc[i]  = 0;
                if (len == '0) begin
                    mDoneAt[i] = cyc + 1;
                end else begin
                    mRun[i]  = 1'b1;
                    mNext[i] = 0;
                    mLen[i]  = int'(len);
                end
            end
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, check, step.
    task automatic applyStimulus(input bit st, input logic [AW-1:0] ln, input bit hd);
        start = st;
        len   = ln;
        hold  = hd;
        #1;
        checkOutput();
        modelAdvance();
        @(negedge clk);
        cyc++;
    endtask

    // Raise reset between clock edges, check outputs clear at once, then
    // hold it across one rising edge.
    task automatic applyReset();
        start = 1'b0;
        hold  = 1'b0;
        len   = '0;
        rst   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mBusy[i] = 1'b0;
            mRun[i] = 1'b0;
            mNext[i] = 0;
            mDoneAt[i] = -1;
            mCyc[i] = 0;
            for (int s = 0; s < 8; s++) pendV[i][s] = 1'b0;
        end
        #1;
        checkOutput();
        for (int i = 0; i < 2; i++) begin
            checkValue($sformatf("lat%0d reset wr_addr", mLat[i]), 32'(wrAddrS[i]), 32'd0);
        end
        @(negedge clk);
        cyc++;
        rst = 1'b0;
    endtask

    // Keep stepping until both references are idle, with optional random
    // stall and ignored start noise; an expired budget counts as a failure.
    task automatic runUntilIdle(input int maxCycles, input int holdPct, input bit noise);
        int n;
        n = 0;
        while ((mBusy[0] || mBusy[1]) && (n < maxCycles)) begin
            bit hd;
            bit st;
            hd = ($urandom_range(99) < holdPct);
            st = noise && mBusy[0] && mBusy[1] && ($urandom_range(3) == 0);
            applyStimulus(st, AW'($urandom_range(1023)), hd);
            n++;
        end
        checks++;
        assert (!(mBusy[0] || mBusy[1])) else begin
            errors++;
            $error("[TB] FAIL idle timeout at cycle %0d: still busy after %0d cycles, required idle", cyc, maxCycles);
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 2; i++) begin
            wrSeen[i] = 0;
            lastDone[i] = -1000;
        end
    endtask

    task automatic checkWrites(input string tag, input int expected);
        for (int i = 0; i < 2; i++) begin
            checkValue($sformatf("lat%0d %s writes", mLat[i], tag), 32'(wrSeen[i]), 32'(expected));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        mLat[0] = 1;
        mLat[1] = 2;
        for (int i = 0; i < 2; i++) mLen[i] = 0;
        start = 1'b0;
        hold = 1'b0;
        len = '0;
        rst = 1'b0;
        clearCounts();

        $display("[TB] reset state");
        applyReset();
        applyStimulus(1'b0, '0, 1'b0);

        $display("[TB] len=4 no stall");
        clearCounts();
        c0 = cyc;
        applyStimulus(1'b1, 10'd4, 1'b0);
        for (int k = 0; k < 7; k++) applyStimulus(1'b0, '0, 1'b0);
        runUntilIdle(50, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkValue("lat1 len4 done delay", 32'(lastDone[0] - c0), 32'd6);
        checkValue("lat2 len4 done delay", 32'(lastDone[1] - c0), 32'd7);
        checkWrites("len4", 4);

        $display("[TB] len=5 with one stall after second read");
        clearCounts();
        c0 = cyc;
        applyStimulus(1'b1, 10'd5, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        runUntilIdle(50, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkValue("lat1 len5 done delay", 32'(lastDone[0] - c0), 32'd8);
        checkValue("lat2 len5 done delay", 32'(lastDone[1] - c0), 32'd9);
        checkWrites("len5", 5);

`ifdef VADD_SEQ_CYCCNT_EN
        $display("[TB] cycle counter len=4 one stall");
        c0 = cyc;
        applyStimulus(1'b1, 10'd4, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        runUntilIdle(50, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkValue("lat1 cycles held", 32'(cycS[0]), 32'd6);
`endif

        $display("[TB] len=0");
        clearCounts();
        c0 = cyc;
        applyStimulus(1'b1, 10'd0, 1'b0);
        runUntilIdle(10, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkValue("lat1 len0 done delay", 32'(lastDone[0] - c0), 32'd1);
        checkValue("lat2 len0 done delay", 32'(lastDone[1] - c0), 32'd1);
        checkWrites("len0", 0);

        $display("[TB] reset during len=8");
        applyStimulus(1'b1, 10'd8, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, 1'b0);
        applyReset();
        clearCounts();
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, '0, 1'b0);
        checkWrites("post-reset", 0);
        applyStimulus(1'b1, 10'd2, 1'b0);
        runUntilIdle(20, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkWrites("len2 after reset", 2);

        $display("[TB] start while busy and on done");
        clearCounts();
        c0 = cyc;
        applyStimulus(1'b1, 10'd3, 1'b0);
        applyStimulus(1'b1, 10'd7, 1'b0);
        for (int k = 0; k < 20 && mDoneAt[0] != cyc; k++) applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, 10'd5, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkValue("lat1 len3 done delay", 32'(lastDone[0] - c0), 32'd5);
        checkWrites("len3", 3);
        clearCounts();
        applyStimulus(1'b1, 10'd2, 1'b0);
        runUntilIdle(20, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkWrites("reaccepted len2", 2);

        $display("[TB] longest vector");
        clearCounts();
        applyStimulus(1'b1, 10'd1023, 1'b0);
        runUntilIdle(3000, 10, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkWrites("len1023", 1023);

        $display("[TB] random operations");
        for (int t = 0; t < 25; t++) begin
            int ln;
            int pct;
            case ($urandom_range(5))
                0: ln = 0;
                1: ln = 1;
                default: ln = int'($urandom_range(40, 2));
            endcase
            pct = int'($urandom_range(50));
            clearCounts();
            applyStimulus(1'b1, AW'(ln), ($urandom_range(1) == 1));
            runUntilIdle(500, pct, 1'b1);
            for (int k = 0; k < int'($urandom_range(2)); k++) applyStimulus(1'b0, '0, 1'b0);
            applyStimulus(1'b0, '0, 1'b0);
            checkWrites("random", ln);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vadd_sequencer.md
VADD_SEQUENCER -- requirements
Module: vadd_sequencer

Interface
REQ-001 Parameter AW, default 10, address width of source and destination BRAMs.
REQ-002 Parameter RD_LAT, default 1, source BRAM read latency in cycles (legal 1..4).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request to run one vector operation; sampled only in IDLE.
REQ-006 len  input  AW  element count; captured on accepted start.
REQ-007 hold  input  1  stall; suppresses new source reads while high.
REQ-008 busy  output  1  high in RUN, DRAIN and DONE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rd_en  output  1  source BRAM read enable (drives both operand BRAMs).
REQ-011 rd_addr  output  AW  source read address.
REQ-012 wr_en  output  1  destination BRAM enable.
REQ-013 wr_we  output  1  destination BRAM write enable; always equal to wr_en.
REQ-014 wr_addr  output  AW  destination write address.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 with len!=0 SHALL capture len, clear index to 0 and enter RUN next cycle.
REQ-017 IDLE: start=1 with len==0 SHALL enter DONE directly; no rd_en or wr_en asserted.
REQ-018 RUN: each cycle with hold=0, rd_en=1, rd_addr=index, index increments; hold=1 gives rd_en=0 and index held.
REQ-019 rd_en and rd_addr SHALL be combinational from state, index and hold (read issued in the same cycle).
REQ-020 Read for index len-1 issued SHALL transition RUN->DRAIN on next edge.
REQ-021 Each issued read SHALL produce exactly one write: wr_en=1 with wr_addr equal to that rd_addr, exactly RD_LAT cycles later, independent of hold.
REQ-022 DRAIN SHALL persist until no write is pending, then enter DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 start while busy SHALL be ignored; len changes after capture SHALL have no effect.
REQ-025 index arithmetic SHALL be AW bits; len up to 2^AW-1 supported, no wrap before len-1.
REQ-026 start in the same cycle DONE exits SHALL not be accepted; earliest acceptance is the following IDLE cycle.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, index 0, write pipeline empty, busy=done=rd_en=wr_en=wr_we=0, rd_addr=wr_addr=0.
REQ-028 rst mid-operation SHALL discard pending writes; no wr_en after rst deasserts until a new start.

Configuration
REQ-029 Macro VADD_SEQ_CYCCNT_EN defined SHALL add output cycles[15:0]: cleared on accepted start, +1 per cycle in RUN/DRAIN, saturating at 16'hFFFF, held from DONE until next accepted start; reset 0.
REQ-030 Without VADD_SEQ_CYCCNT_EN the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package vadd_pkg SHALL hold the default AW constant and the FSM state typedef.
REQ-032 Sub-module vadd_seq_dly SHALL implement the RD_LAT-deep valid+address shift register feeding wr_en/wr_addr.

Verification
REQ-033 len=4, RD_LAT=1, hold=0: rd_addr 0,1,2,3 in cycles 1-4 after start; wr_addr 0-3 in cycles 2-5; done in cycle 6.
REQ-034 len=5, RD_LAT=2, hold=1 for one cycle after second read: rd_addr 0,1,-,2,3,4; each wr_addr exactly 2 cycles after its read; 5 writes total, then done.
REQ-035 len=0: done pulse one cycle after start; rd_en and wr_en never high.
REQ-036 len=8, rst asserted after third read: all outputs 0 asynchronously; no wr_en afterwards; new start len=2 completes normally.
REQ-037 start pulsed during RUN and on DONE cycle with len=3: ignored; exactly 3 writes; busy low one cycle before re-acceptance.
REQ-038 VADD_SEQ_CYCCNT_EN, len=4, RD_LAT=1, one hold cycle: cycles=6 held after done.
